// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: gap/show timing, LFSR mole pick, hit/miss judgement,
// saturating score, difficulty level and game-over, all on one clock.
module mole_round_scheduler #(
    parameter int GAP_CYCLES = 150000000,
    parameter int SHOW_BASE  = 200000000,
    parameter int MAX_MISSES = 3,
    parameter int CNT_W      = 30
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       game_i,
    input  logic [2:0] button_i,
    output logic [2:0] moles_o,
    output logic [7:0] score_o,
    output logic [1:0] misses_o,
    output logic [1:0] level_o,
    output logic       game_over_o,
    output logic       round_done_o
);

    typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LEN = CNT_W'(SHOW_BASE);
    localparam logic [1:0]       MISS_LIM = 2'(MAX_MISSES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lfsr_q, lfsr_d;
    logic [2:0]       btn_prev_q, btn_prev_d;
    logic [2:0]       moles_q, moles_d;
    logic [7:0]       score_q, score_d;
    logic [1:0]       misses_q, misses_d;
    logic [1:0]       level_q, level_d;
    logic             game_over_q, game_over_d;
    logic             round_done_q, round_done_d;

    logic [2:0]       edge_c;
    logic [2:0]       lfsr_nxt;
    logic [1:0]       miss_inc;

    function automatic logic [2:0] mole_of(input logic [2:0] v);
        case (v)
            3'd1, 3'd5:       mole_of = 3'b001;
            3'd3, 3'd4, 3'd6: mole_of = 3'b100;
            default:          mole_of = 3'b010;
        endcase
    endfunction

    function automatic logic [1:0] level_of(input logic [7:0] s);
        if (s <= 8'd2)       level_of = 2'd0;
        else if (s <= 8'd5)  level_of = 2'd1;
        else if (s <= 8'd10) level_of = 2'd2;
        else                 level_of = 2'd3;
    endfunction

    always_comb begin
        edge_c       = button_i & ~btn_prev_q;
        lfsr_nxt     = {lfsr_q[1:0], ~(lfsr_q[2] ^ lfsr_q[1])};
        miss_inc     = misses_q + 2'd1;
        state_d      = state_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        btn_prev_d   = button_i;
        moles_d      = moles_q;
        score_d      = score_q;
        misses_d     = misses_q;
        level_d      = level_of(score_q);
        game_over_d  = game_over_q;
        round_done_d = 1'b0;

        if (!game_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            lfsr_d      = '0;
            btn_prev_d  = '0;
            moles_d     = '0;
            score_d     = '0;
            misses_d    = '0;
            level_d     = '0;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end
                GAP: begin
                    moles_d = '0;
                    if (cnt_q == '0) begin
                        lfsr_d  = lfsr_nxt;
                        moles_d = mole_of(lfsr_nxt);
                        // show length follows the level at the moment the mole rises
                        cnt_d   = (SHOW_LEN >> level_q) - CNT_W'(1);
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    if (edge_c == moles_q) begin
                        score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        moles_d      = '0;
                        round_done_d = 1'b1;
                        state_d      = GAP;
                        cnt_d        = GAP_LD;
                    end else begin
                        // a wrong press and the timeout may both land on the last cycle
                        if (edge_c != '0)
                            score_d = (score_q == 8'd0) ? score_q : score_q - 8'd1;
                        if (cnt_q == '0) begin
                            misses_d     = miss_inc;
                            moles_d      = '0;
                            round_done_d = 1'b1;
                            if (miss_inc == MISS_LIM) begin
                                state_d     = OVER;
                                game_over_d = 1'b1;
                            end else begin
                                state_d = GAP;
                                cnt_d   = GAP_LD;
                            end
                        end
                    end
                end
                OVER: begin
                    moles_d     = '0;
                    game_over_d = 1'b1;
                    level_d     = level_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lfsr_q       <= '0;
            btn_prev_q   <= '0;
            moles_q      <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            level_q      <= '0;
            game_over_q  <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            btn_prev_q   <= btn_prev_d;
            moles_q      <= moles_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            level_q      <= level_d;
            game_over_q  <= game_over_d;
            round_done_q <= round_done_d;
        end
    end

    assign moles_o      = moles_q;
    assign score_o      = score_q;
    assign misses_o     = misses_q;
    assign level_o      = level_q;
    assign game_over_o  = game_over_q;
    assign round_done_o = round_done_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: round-level reference model checked every cycle,
// plus directed scenarios with hand-derived expectations.
module tb_mole_round_scheduler;

    localparam int GAP = 4;
    localparam int SB  = 16;
    localparam int MM  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game = 1'b0;
    logic [2:0] button = 3'b000;
    logic [2:0] moles;
    logic [7:0] score;
    logic [1:0] misses, level;
    logic       game_over, round_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mole_round_scheduler #(
        .GAP_CYCLES(GAP), .SHOW_BASE(SB), .MAX_MISSES(MM), .CNT_W(30)
    ) dut (
        .clock_i(clk), .reset_i(rst), .game_i(game), .button_i(button),
        .moles_o(moles), .score_o(score), .misses_o(misses), .level_o(level),
        .game_over_o(game_over), .round_done_o(round_done)
    );

    // Mole sequence as documented, and the value-to-mole mapping.
    int seq_v  [7] = '{1, 3, 6, 5, 2, 4, 0};
    int mole_v [8] = '{2, 1, 2, 4, 4, 1, 4, 2};

    bit         m_active, m_vis, m_over, m_done;
    int         m_left, m_idx = 6, m_score, m_misses, m_lvl;
    logic [2:0] m_prev = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lvl_of(input int s);
        if (s <= 2) return 0;
        if (s <= 5) return 1;
        if (s <= 10) return 2;
        return 3;
    endfunction

    task automatic model_step(input logic r, input logic g, input logic [2:0] b);
        logic [2:0] e;
        int old_s, tgt;
        e      = b & ~m_prev;
        old_s  = m_score;
        m_done = 0;
        if (r || !g) begin
            m_active = 0; m_vis = 0; m_over = 0; m_left = 0; m_idx = 6;
            m_score = 0; m_misses = 0; m_lvl = 0; m_prev = 3'b000;
        end else begin
            m_prev = b;
            if (!m_over) begin
                if (!m_active) begin
                    m_active = 1; m_left = GAP;
                end else if (!m_vis) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_idx  = (m_idx + 1) % 7;
                        m_vis  = 1;
                        m_left = SB >> m_lvl;
                    end
                end else begin
                    tgt = mole_v[seq_v[m_idx]];
                    m_left--;
                    if (int'(e) == tgt) begin
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_vis = 0; m_done = 1; m_left = GAP;
                    end else begin
                        if (e != 0) m_score = (m_score > 0) ? m_score - 1 : 0;
                        if (m_left == 0) begin
                            m_misses++;
                            m_vis = 0; m_done = 1;
                            if (m_misses == MM) m_over = 1;
                            else m_left = GAP;
                        end
                    end
                end
                m_lvl = lvl_of(old_s);
            end
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            model_step(rst, game, button);
            #1;
            chk("m_moles", moles, m_vis ? mole_v[seq_v[m_idx]] : 0);
            chk("m_score", score, m_score);
            chk("m_misses", misses, m_misses);
            chk("m_level", level, m_lvl);
            chk("m_game_over", game_over, m_over);
            chk("m_round_done", round_done, m_done);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_mole(input string tag);
        int n = 0;
        while (moles == 3'b000 && n < 60) begin tick(1); n++; end
        chk({tag, "_appear"}, moles != 3'b000, 1);
    endtask

    task automatic hit(input string tag, input logic [2:0] m);
        wait_mole(tag);
        chk({tag, "_mole"}, moles, m);
        button = m; tick(1);
        chk({tag, "_cleared"}, moles, 0);
        chk({tag, "_done"}, round_done, 1);
        button = 3'b000; tick(1);
    endtask

    task automatic timeout_len(input string tag, input logic [2:0] m, input int len);
        int n = 0;
        wait_mole(tag);
        chk({tag, "_mole"}, moles, m);
        while (moles != 3'b000 && n < 300) begin tick(1); n++; end
        chk({tag, "_len"}, n, len);
    endtask

    task automatic final_hit(input string tag, input logic [2:0] m, input int len);
        wait_mole(tag);
        chk({tag, "_mole"}, moles, m);
        tick(len - 1);
        chk({tag, "_still_up"}, moles, m);
        button = m; tick(1);
        chk({tag, "_cleared"}, moles, 0);
        chk({tag, "_done"}, round_done, 1);
        button = 3'b000; tick(1);
    endtask

    initial begin
        tick(2);
        chk("rst_moles", moles, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_level", level, 0);
        chk("rst_over", game_over, 0);
        chk("rst_done", round_done, 0);

        rst = 1'b0; game = 1'b1;
        for (int i = 1; i <= 4; i++) begin tick(1); chk("gap_dark", moles, 0); end
        tick(1);  chk("first_mole", moles, 3'b001);
        tick(15); chk("mole_16th", moles, 3'b001);
        tick(1);
        chk("r1_timeout_moles", moles, 0);
        chk("r1_misses", misses, 1);
        chk("r1_done", round_done, 1);
        tick(1);  chk("r1_done_pulse", round_done, 0);
        tick(3);  chk("r2_mole", moles, 3'b100);

        // wrong press at score 0 saturates, mole stays
        button = 3'b001; tick(1);
        chk("r2_wrong_score", score, 0);
        chk("r2_wrong_mole", moles, 3'b100);
        button = 3'b000; tick(1);
        button = 3'b100; tick(1);
        chk("r2_hit_score", score, 1);
        chk("r2_hit_moles", moles, 0);
        button = 3'b000; tick(1);

        // held press counts once and does not whack the next mole
        wait_mole("r3");
        chk("r3_mole", moles, 3'b100);
        button = 3'b100; tick(1);
        chk("r3_hit_score", score, 2);
        chk("r3_done", round_done, 1);
        tick(4);
        chk("r3_hold_score", score, 2);
        chk("r4_mole_under_hold", moles, 3'b001);
        button = 3'b000;
        hit("r4", 3'b001);
        chk("r4_score", score, 3);

        timeout_len("r5_lvl1", 3'b010, 8);
        chk("r5_misses", misses, 2);
        chk("r5_level", level, 1);

        hit("r6", 3'b100);
        hit("r7", 3'b010);
        hit("r8", 3'b001);
        chk("r8_score", score, 6);

        final_hit("r9_lvl2", 3'b100, 4);
        chk("r9_score", score, 7);
        chk("r9_misses", misses, 2);

        hit("r10", 3'b100);
        hit("r11", 3'b001);
        hit("r12", 3'b010);
        hit("r13", 3'b100);
        chk("r13_score", score, 11);

        timeout_len("r14_lvl3", 3'b010, 2);
        chk("r14_misses", misses, 3);
        chk("r14_over", game_over, 1);
        chk("r14_level", level, 3);

        // frozen in OVER
        button = 3'b111; tick(1); button = 3'b000; tick(1);
        button = 3'b010; tick(2); button = 3'b000; tick(3);
        chk("over_score", score, 11);
        chk("over_flag", game_over, 1);
        chk("over_moles", moles, 0);

        game = 1'b0; tick(1);
        chk("clr_score", score, 0);
        chk("clr_misses", misses, 0);
        chk("clr_over", game_over, 0);
        chk("clr_level", level, 0);

        // one-cycle game glitch shows no mole
        game = 1'b1; tick(1); game = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(1); chk("glitch_dark", moles, 0); end

        game = 1'b1;
        wait_mole("g2");
        chk("g2_mole", moles, 3'b001);
        rst = 1'b1; tick(1);
        chk("mid_rst_moles", moles, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_over", game_over, 0);
        chk("mid_rst_done", round_done, 0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin tick(1); chk("rst_gap_dark", moles, 0); end
        tick(1); chk("rst_first_mole", moles, 3'b001);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
